// File: rtl/video_pkg.sv
// Shared constants for the video sync/blank cleaner: output polarity codes and default widths.
// Latency: n/a (constants only).
// Backpressure: n/a; the video path is free-running and paced by ce_pix alone.
package video_pkg;

    localparam int POL_HIGH = 1;
    localparam int POL_LOW  = 0;

    localparam int CW_DEF   = 8;
    localparam int MW_DEF   = 12;
    localparam int CNTW_DEF = 16;

endpackage

// File: rtl/sync_pol_detect.sv
// Sync polarity detector: learns which sync level is the active one and emits active-high sync.
// Latency: sync_out is combinational from sync_in; inv settles after two agreeing periods.
// Backpressure: none; runs every clk_vid.
// Ports: clk_vid, rst_n (sync, active-low), sync_in (any polarity), sync_out (active-high), inv.
module sync_pol_detect
    import video_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
) (
    input  logic clk_vid,
    input  logic rst_n,
    input  logic sync_in,
    output logic sync_out,
    output logic inv
);

    localparam logic [CNTW-1:0] ONE = 1;

    logic            s1, s2;
    logic            pend;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] low_len;
    logic            rise, fall;
    logic            cand;

    assign rise = s1 & ~s2;
    assign fall = s2 & ~s1;
    // At a falling edge cnt holds the length of the high level just ended.
    // The longer level is taken as the inactive one.
    assign cand = (cnt > low_len);

    always_ff @(posedge clk_vid) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            low_len <= '0;
            pend    <= 1'b0;
            inv     <= 1'b1;
        end else begin
            s1 <= sync_in;
            s2 <= s1;
            if (s1 != s2)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + ONE;
            if (rise)
                low_len <= cnt;
            if (fall) begin
                // Equal lengths give no opinion and also break a pending run.
                // A disagreement must be seen on two falls in a row before inv moves,
                // so one odd period cannot flip the polarity.
                if ((cnt != low_len) && (cand != inv)) begin
                    if (pend) begin
                        inv  <= cand;
                        pend <= 1'b0;
                    end else begin
                        pend <= 1'b1;
                    end
                end else begin
                    pend <= 1'b0;
                end
            end
        end
    end

    assign sync_out = sync_in ^ inv;

endmodule

// File: rtl/video_cleaner_pol.sv
// Sync/blank cleaner: polarity-normalised syncs, VBlank realigned to line start, DE, active-size measurement.
// Latency: 1 ce_pix for colour, sync and HBlank_out; VBlank_out moves only at a line's first active pixel.
// Backpressure: none; all output registers hold while ce_pix=0, only the sync detectors keep running.
// Ports: clk_vid, rst_n, ce_pix, R/G/B, HSync/VSync, HBlank/VBlank in; VGA_*, HBlank_out/VBlank_out, h_active/v_active/meas_valid out.
module video_cleaner_pol
    import video_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int CNTW   = CNTW_DEF,
    parameter int HS_POS = POL_LOW,
    parameter int VS_POS = POL_LOW,
    parameter int MW     = MW_DEF
) (
    input  logic          clk_vid,
    input  logic          rst_n,
    input  logic          ce_pix,
    input  logic [CW-1:0] R,
    input  logic [CW-1:0] G,
    input  logic [CW-1:0] B,
    input  logic          HSync,
    input  logic          VSync,
    input  logic          HBlank,
    input  logic          VBlank,
    output logic [CW-1:0] VGA_R,
    output logic [CW-1:0] VGA_G,
    output logic [CW-1:0] VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE,
    output logic          HBlank_out,
    output logic          VBlank_out,
    output logic [MW-1:0] h_active,
    output logic [MW-1:0] v_active,
    output logic          meas_valid
);

    localparam logic          HS_IDLE = (HS_POS == POL_HIGH) ? 1'b0 : 1'b1;
    localparam logic          VS_IDLE = (VS_POS == POL_HIGH) ? 1'b0 : 1'b1;
    localparam logic [MW-1:0] ONE_M   = 1;

    logic          hs, vs;
    logic          hs_inv_unused, vs_inv_unused;
    logic          hbl, vbl;
    logic          line_start, hb_rise, vb_rise;
    logic [MW-1:0] px, px_cnt, line_w, line_w_nx, ln, ln_nx;

    sync_pol_detect #(.CNTW(CNTW)) u_hs (
        .clk_vid  (clk_vid),
        .rst_n    (rst_n),
        .sync_in  (HSync),
        .sync_out (hs),
        .inv      (hs_inv_unused)
    );

    sync_pol_detect #(.CNTW(CNTW)) u_vs (
        .clk_vid  (clk_vid),
        .rst_n    (rst_n),
        .sync_in  (VSync),
        .sync_out (vs),
        .inv      (vs_inv_unused)
    );

    assign hbl        = hs | HBlank;
    assign vbl        = vs | VBlank;
    assign line_start = HBlank_out & ~hbl;
    assign hb_rise    = ~HBlank_out & hbl;
    assign vb_rise    = line_start & vbl & ~VBlank_out;
    assign VGA_DE     = ~(HBlank_out | VBlank_out);

    // The ce on which HBlank_out rises still shows the last DE pixel, so it is
    // included before the line width is taken. Frame latching uses the _nx
    // values so a line ending on the same ce as the frame is counted first.
    always_comb begin
        px_cnt    = px;
        line_w_nx = line_w;
        ln_nx     = ln;
        if (VGA_DE && (px != '1))
            px_cnt = px + ONE_M;
        if (hb_rise && (px_cnt != '0)) begin
            line_w_nx = px_cnt;
            if (ln != '1)
                ln_nx = ln + ONE_M;
        end
    end

    always_ff @(posedge clk_vid) begin
        if (!rst_n) begin
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
            VGA_HS     <= HS_IDLE;
            VGA_VS     <= VS_IDLE;
            HBlank_out <= 1'b1;
            VBlank_out <= 1'b1;
            px         <= '0;
            line_w     <= '0;
            ln         <= '0;
            h_active   <= '0;
            v_active   <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (ce_pix) begin
                VGA_R      <= R;
                VGA_G      <= G;
                VGA_B      <= B;
                VGA_HS     <= hs ^ HS_IDLE;
                VGA_VS     <= vs ^ VS_IDLE;
                HBlank_out <= hbl;
                if (line_start)
                    VBlank_out <= vbl;
                px     <= hb_rise ? '0 : px_cnt;
                line_w <= line_w_nx;
                if (vb_rise) begin
                    h_active   <= line_w_nx;
                    v_active   <= ln_nx;
                    ln         <= '0;
                    meas_valid <= 1'b1;
                end else begin
                    ln <= ln_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_cleaner_pol.sv
// Testbench for video_cleaner_pol: random frames scored against a frame-level model,
// plus directed polarity-switch, glitch, counter-saturation and mid-frame reset cases.
// Ports: none (top-level bench).
module tb_video_cleaner_pol;

    localparam int CW   = 8;
    localparam int MW   = 12;
    localparam int CNTW = 12;

    logic          clk_vid = 1'b0;
    logic          rst_n   = 1'b0;
    logic          ce_pix  = 1'b0;
    logic [CW-1:0] R = '0, G = '0, B = '0;
    logic          HSync = 1'b1, VSync = 1'b1, HBlank = 1'b1, VBlank = 1'b1;
    logic [CW-1:0] VGA_R, VGA_G, VGA_B;
    logic          VGA_HS, VGA_VS, VGA_DE, HBlank_out, VBlank_out, meas_valid;
    logic [MW-1:0] h_active, v_active;

    video_cleaner_pol #(
        .CW(CW), .CNTW(CNTW), .HS_POS(0), .VS_POS(0), .MW(MW)
    ) dut (
        .clk_vid    (clk_vid),
        .rst_n      (rst_n),
        .ce_pix     (ce_pix),
        .R          (R),
        .G          (G),
        .B          (B),
        .HSync      (HSync),
        .VSync      (VSync),
        .HBlank     (HBlank),
        .VBlank     (VBlank),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_DE     (VGA_DE),
        .HBlank_out (HBlank_out),
        .VBlank_out (VBlank_out),
        .h_active   (h_active),
        .v_active   (v_active),
        .meas_valid (meas_valid)
    );

    always #5 clk_vid = ~clk_vid;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard: expected (width, height) per frame
    typedef struct {
        int w;
        int h;
    } meas_t;
    meas_t exp_q[$];
    meas_t m;
    bit    prev_mv = 1'b0;

    always @(negedge clk_vid) begin
        if (meas_valid === 1'b1) begin
            check("meas_valid_one_clk", {31'd0, prev_mv}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL meas_unexpected: got h=%0d v=%0d, expected no pulse", h_active, v_active);
            end else begin
                m = exp_q.pop_front();
                check("h_active", {20'd0, h_active}, m.w);
                check("v_active", {20'd0, v_active}, m.h);
            end
        end
        prev_mv = (meas_valid === 1'b1);
    end

    // ---------------- per-ce colour and HBlank_out model (1 ce latency, hold otherwise)
    logic [3*CW-1:0] exp_rgb;
    logic            exp_hb;
    bit              chk_hb = 1'b1;

    always @(posedge clk_vid) begin
        if (!rst_n) begin
            exp_rgb = '0;
            exp_hb  = 1'b1;
        end else if (ce_pix) begin
            exp_rgb = {R, G, B};
            exp_hb  = HBlank | ~HSync;   // HSync is active-low while this check is enabled
        end
        #1;
        check("rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb});
        if (chk_hb)
            check("hblank_out", {31'd0, HBlank_out}, {31'd0, exp_hb});
    end

    // ---------------- stimulus
    int per = 1;   // clk_vid cycles per ce_pix

    task automatic pix(input logic hb, input logic vb, input logic hsy, input logic vsy);
        for (int k = 0; k < per; k++) begin
            @(negedge clk_vid);
            HBlank = hb;
            VBlank = vb;
            HSync  = hsy;
            VSync  = vsy;
            R      = CW'($urandom);
            G      = CW'($urandom);
            B      = CW'($urandom);
            ce_pix = (k == per - 1);
        end
    endtask

    // 8 blank pixels (HSync low on 2..4), then w active pixels; VBlank may rise at pixel vb_at.
    task automatic line(input int w, input bit vb0, input int vb_at, input bit vs_low);
        for (int i = 0; i < 8; i++)
            pix(1'b1, vb0, !(i >= 2 && i <= 4), !vs_low);
        for (int i = 0; i < w; i++)
            pix(1'b0, (vb_at >= 0 && i >= vb_at) ? 1'b1 : vb0, 1'b1, !vs_low);
    endtask

    task automatic frame();
        int nact, w, mid;
        meas_t e;
        nact = $urandom_range(6, 2);
        w    = 0;
        for (int l = 0; l < nact; l++) begin
            w   = $urandom_range(24, 4);
            mid = -1;
            if (l == nact - 1 && $urandom_range(1, 0) == 1)
                mid = $urandom_range(w - 1, 1);   // VBlank asserted mid-line: line must stay whole
            line(w, 1'b0, mid, 1'b0);
        end
        e.w = w;       // width of the last active line
        e.h = nact;    // number of lines that started active
        exp_q.push_back(e);
        for (int v = 0; v < 3; v++)
            line($urandom_range(24, 4), 1'b1, -1, v == 1);
    endtask

    task automatic hold(input logic lvl, input int n);
        repeat (n) begin
            @(negedge clk_vid);
            HSync  = lvl;
            HBlank = 1'b1;
            VBlank = 1'b1;
            ce_pix = 1'b1;
            R      = CW'($urandom);
        end
    endtask

    task automatic out_state(input string tag);
        check({tag, "_de"},  {31'd0, VGA_DE},     32'd0);
        check({tag, "_hs"},  {31'd0, VGA_HS},     32'd1);
        check({tag, "_vs"},  {31'd0, VGA_VS},     32'd1);
        check({tag, "_vbl"}, {31'd0, VBlank_out}, 32'd1);
        check({tag, "_h"},   {20'd0, h_active},   32'd0);
        check({tag, "_v"},   {20'd0, v_active},   32'd0);
        check({tag, "_mv"},  {31'd0, meas_valid}, 32'd0);
    endtask

    initial begin
        // reset with busy inputs: outputs must still come up in their idle state
        rst_n  = 1'b0;
        ce_pix = 1'b1;
        R = 8'hA5; G = 8'h5A; B = 8'hFF;
        HBlank = 1'b0; VBlank = 1'b0;
        repeat (3) @(negedge clk_vid);
        out_state("reset");
        HBlank = 1'b1; VBlank = 1'b1;
        rst_n  = 1'b1;
        ce_pix = 1'b0;

        // random frames, random ce_pix rate
        for (int f = 0; f < 6; f++) begin
            per = $urandom_range(4, 1);
            frame();
        end

        // reset part-way through a frame: partial counts must be discarded
        per = 2;
        line(10, 1'b0, -1, 1'b0);
        line(12, 1'b0, -1, 1'b0);
        @(negedge clk_vid);
        HSync  = 1'b1;
        rst_n  = 1'b0;
        ce_pix = 1'b1;
        @(posedge clk_vid);
        #1;
        out_state("midreset");
        @(negedge clk_vid);
        rst_n  = 1'b1;
        ce_pix = 1'b0;
        per = 4;
        frame();
        repeat (4) @(negedge clk_vid);
        check("queue_drained", exp_q.size(), 32'd0);

        // polarity section: blanking held, only HSync moves
        chk_hb = 1'b0;
        for (int p = 0; p < 3; p++) begin
            hold(1'b1, 150);
            check("al_idle_hs", {31'd0, VGA_HS}, 32'd1);
            hold(1'b1, 150);
            hold(1'b0, 15);
            check("al_pulse_hs", {31'd0, VGA_HS}, 32'd0);
            hold(1'b0, 15);
        end
        check("vs_idle", {31'd0, VGA_VS}, 32'd1);

        // input switches to active-high: inv must flip at the 2nd reversed period
        hold(1'b0, 150);
        check("rev1_low_hs", {31'd0, VGA_HS}, 32'd0);
        hold(1'b0, 150);
        hold(1'b1, 30);
        hold(1'b0, 150);
        check("rev2_low_hs", {31'd0, VGA_HS}, 32'd0);
        hold(1'b0, 150);
        hold(1'b1, 30);
        hold(1'b0, 150);
        check("rev3_low_hs", {31'd0, VGA_HS}, 32'd1);
        hold(1'b0, 150);
        hold(1'b1, 15);
        check("rev3_pulse_hs", {31'd0, VGA_HS}, 32'd0);
        hold(1'b1, 15);

        // one glitch period shaped like active-low must not flip inv
        hold(1'b1, 400);
        check("glitch_high_hs", {31'd0, VGA_HS}, 32'd0);
        hold(1'b0, 30);
        hold(1'b0, 150);
        check("glitch_ignored_hs", {31'd0, VGA_HS}, 32'd1);
        hold(1'b0, 150);
        hold(1'b1, 30);
        hold(1'b0, 150);
        check("after_glitch_hs", {31'd0, VGA_HS}, 32'd1);
        hold(1'b0, 150);
        hold(1'b1, 30);

        // level held past 2^CNTW clocks: counter saturates, polarity unaffected
        for (int p = 0; p < 2; p++) begin
            hold(1'b0, (1 << CNTW) + 20);
            check("cnt_saturated", {{(32 - CNTW){1'b0}}, dut.u_hs.cnt}, (1 << CNTW) - 1);
            hold(1'b1, 30);
        end
        hold(1'b0, 150);
        check("sat_polarity_hs", {31'd0, VGA_HS}, 32'd1);
        hold(1'b0, 10);

        check("no_extra_meas", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
